// File: rtl/arb_pkg.sv
// Shared definitions for the synchronous round-robin arbiter:
// FSM state encoding and the select-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKD = 2'd2,
    RTZ  = 2'd3
  } arb_state_t;

  // A select index needs at least one bit, even for N=1 or N=2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_rr_arbiter_if.sv
// Requester and resource handshake bundle of the arbiter.
// The slave side is the arbiter; the master side is its environment.
interface sync_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N-1:0]     req;
  logic [N-1:0]     ack;
  logic             res_req;
  logic             res_ack;
  logic [SEL_W-1:0] res_sel;
  logic             busy;
  logic             err;

  modport master (output req, res_ack, input ack, res_req, res_sel, busy, err);
  modport slave  (input req, res_ack, output ack, res_req, res_sel, busy, err);
endinterface

// File: rtl/rr_arb_pick.sv
// Combinational round-robin winner search starting at ptr and wrapping at N-1.
module rr_arb_pick import arb_pkg::*; #(
  parameter int N     = 4,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  int               j;
  logic [SEL_W-1:0] js;

  // Walk from lowest to highest priority so the entry nearest ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    js    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      js = SEL_W'(j);
      if (req[js]) begin
        valid = 1'b1;
        idx   = js;
      end
    end
  end

endmodule

// File: rtl/sync_rr_arbiter.sv
// Clocked N-way round-robin arbiter with four-phase handshakes on both sides,
// rotating priority and a res_ack watchdog.
module sync_rr_arbiter import arb_pkg::*; #(
  parameter int N       = 4,
  parameter int SEL_W   = clog2_min1(N),
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic clk,
  input logic reset,
  sync_rr_arbiter_if.slave bus
);

  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [TW-1:0]    wdog;
  logic [N-1:0]     ack_r;
  logic             res_req_r;
  logic [SEL_W-1:0] res_sel_r;
  logic             busy_r;
  logic             err_r;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             waiting;

  rr_arb_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Cycles where the awaited res_ack level has not yet arrived.
  assign waiting = ((state == REQ) && !bus.res_ack) ||
                   ((state == RTZ) &&  bus.res_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      wdog      <= '0;
      ack_r     <= '0;
      res_req_r <= 1'b0;
      res_sel_r <= '0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          res_sel_r <= pick_idx;
          res_req_r <= 1'b1;
          busy_r    <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          if (!bus.req[res_sel_r]) err_r <= 1'b1;
          if (bus.res_ack) begin
            ack_r <= {{(N-1){1'b0}}, 1'b1} << res_sel_r;
            state <= ACKD;
          end
        end
        ACKD: if (!bus.req[res_sel_r]) begin
          res_req_r <= 1'b0;
          state     <= RTZ;
        end
        RTZ: if (!bus.res_ack) begin
          ack_r  <= '0;
          ptr    <= (res_sel_r == SEL_W'(N - 1)) ? '0 : res_sel_r + 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A non-waiting cycle is either a state change or a state with nothing to time.
      if (waiting) begin
        if (wdog != TMO) begin
          wdog <= wdog + 1'b1;
          if ((TIMEOUT != 0) && ((wdog + 1'b1) == TMO)) err_r <= 1'b1;
        end
      end else begin
        wdog <= '0;
      end
    end
  end

  assign bus.ack     = ack_r;
  assign bus.res_req = res_req_r;
  assign bus.res_sel = res_sel_r;
  assign bus.busy    = busy_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Directed bench for sync_rr_arbiter: a 4-way instance driven step by step and a
// 3-way instance with a zero-latency resource and always-pending requesters.
module tb_sync_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sync_rr_arbiter_if #(.N(4), .SEL_W(2)) b4();
  sync_rr_arbiter_if #(.N(3), .SEL_W(2)) b3();

  sync_rr_arbiter #(.N(4), .SEL_W(2), .TIMEOUT(5), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  sync_rr_arbiter #(.N(3), .SEL_W(2), .TIMEOUT(0), .TW(8)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  // 3-way environment: resource answers instantly, requesters release on ack and re-raise after.
  assign b3.res_ack = b3.res_req;
  assign b3.req     = 3'b111 & ~b3.ack;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase transaction on the 4-way instance, starting in IDLE with req already set.
  task automatic grant(input int w, input bit rearm);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    step();
    chk("grant_res_req", 32'(b4.res_req), 32'd1);
    chk("grant_res_sel", 32'(b4.res_sel), 32'(w));
    chk("grant_busy",    32'(b4.busy),    32'd1);
    b4.res_ack = 1'b1;
    step();
    chk("grant_ack",     32'(b4.ack),     32'(oh));
    b4.req[w] = 1'b0;
    step();
    chk("grant_rtz_req", 32'(b4.res_req), 32'd0);
    chk("grant_rtz_ack", 32'(b4.ack),     32'(oh));
    b4.res_ack = 1'b0;
    step();
    chk("grant_ack_clr", 32'(b4.ack),     32'd0);
    chk("grant_idle",    32'(b4.busy),    32'd0);
    if (rearm) b4.req[w] = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    b4.req     = '0;
    b4.res_ack = 1'b0;
    step();
    step();
    chk("rst_ack",     32'(b4.ack),     32'd0);
    chk("rst_res_req", 32'(b4.res_req), 32'd0);
    chk("rst_res_sel", 32'(b4.res_sel), 32'd0);
    chk("rst_busy",    32'(b4.busy),    32'd0);
    chk("rst_err",     32'(b4.err),     32'd0);
    reset = 1'b0;

    // 3-way: one grant every 4 clocks, order 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      step();
      chk("n3_res_req", 32'(b3.res_req), 32'd1);
      chk("n3_res_sel", 32'(b3.res_sel), 32'(k % 3));
      step();
      step();
      step();
    end
    chk("n3_err", 32'(b3.err), 32'd0);

    // Single requester, resource acks two cycles after res_req.
    b4.req = 4'b0010;
    step();
    chk("t1_res_req", 32'(b4.res_req), 32'd1);
    chk("t1_res_sel", 32'(b4.res_sel), 32'd1);
    step();
    chk("t1_no_ack",  32'(b4.ack),     32'd0);
    b4.res_ack = 1'b1;
    step();
    chk("t1_ack",     32'(b4.ack),     32'b0010);
    b4.req = 4'b0000;
    step();
    chk("t1_rtz",     32'(b4.res_req), 32'd0);
    b4.res_ack = 1'b0;
    step();
    chk("t1_ack_clr", 32'(b4.ack),     32'd0);
    // ptr is now 2: of {1,3}, 3 must win.
    b4.req = 4'b1010;
    grant(3, 1'b0);
    b4.req = 4'b0000;

    // Round-robin with all four pending; ptr is back at 0.
    b4.req = 4'b1111;
    grant(0, 1'b1);
    grant(1, 1'b1);
    grant(2, 1'b1);
    grant(3, 1'b1);
    grant(0, 1'b1);
    b4.req = 4'b0000;

    // Park ptr at 3, then contention between 3 and 0 across the wrap.
    b4.req = 4'b0100;
    grant(2, 1'b0);
    b4.req = 4'b1001;
    grant(3, 1'b1);
    grant(0, 1'b0);
    b4.req = 4'b0000;
    chk("t3_err", 32'(b4.err), 32'd0);

    // Watchdog: res_ack withheld in REQ, err appears on the 5th wait cycle.
    b4.req = 4'b0001;
    step();
    chk("t4_sel", 32'(b4.res_sel), 32'd0);
    step();
    step();
    step();
    step();
    chk("t4_err_pre", 32'(b4.err), 32'd0);
    step();
    chk("t4_err", 32'(b4.err), 32'd1);
    b4.res_ack = 1'b1;
    step();
    chk("t4_ack", 32'(b4.ack), 32'b0001);
    b4.req = 4'b0000;
    step();
    b4.res_ack = 1'b0;
    step();
    chk("t4_idle",       32'(b4.busy), 32'd0);
    chk("t4_err_sticky", 32'(b4.err),  32'd1);

    // Reset while in ACKD aborts at once and clears err and ptr.
    b4.req = 4'b0100;
    step();
    chk("t6_sel", 32'(b4.res_sel), 32'd2);
    b4.res_ack = 1'b1;
    step();
    chk("t6_ackd", 32'(b4.ack), 32'b0100);
    reset = 1'b1;
    step();
    reset      = 1'b0;
    b4.req     = 4'b0000;
    b4.res_ack = 1'b0;
    chk("t6_ack",     32'(b4.ack),     32'd0);
    chk("t6_res_req", 32'(b4.res_req), 32'd0);
    chk("t6_busy",    32'(b4.busy),    32'd0);
    chk("t6_err",     32'(b4.err),     32'd0);
    chk("t6_sel_rst", 32'(b4.res_sel), 32'd0);
    // ptr was 1 before reset; a cleared ptr picks 0 out of {0,1}.
    b4.req = 4'b0011;
    grant(0, 1'b0);
    b4.req = 4'b0000;

    // Early withdraw: winner drops req while still in REQ.
    b4.req = 4'b0100;
    step();
    chk("t5_sel", 32'(b4.res_sel), 32'd2);
    b4.req = 4'b0000;
    step();
    chk("t5_err", 32'(b4.err), 32'd1);
    b4.res_ack = 1'b1;
    step();
    chk("t5_ack", 32'(b4.ack), 32'b0100);
    step();
    chk("t5_rtz", 32'(b4.res_req), 32'd0);
    b4.res_ack = 1'b0;
    step();
    chk("t5_ack_clr", 32'(b4.ack),  32'd0);
    chk("t5_idle",    32'(b4.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
